// File: rtl/sample_reader_pkg.sv
// Shared constants and address helpers for the sample buffer.
// The write-address generator uses the same definitions.
package sample_reader_pkg;

    localparam int unsigned DEPTH     = 62500;
    localparam int unsigned LAST_ADDR = DEPTH - 1;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Circular increment: LAST_ADDR wraps to 0, never to DEPTH.
    function automatic addr_t addr_wrap_inc(input addr_t addr);
        return (addr == addr_t'(LAST_ADDR)) ? '0 : addr + addr_t'(1);
    endfunction

endpackage

// File: rtl/sample_reader_if.sv
// Memory read port plus serializer valid/ready handshake of the sample reader.
interface sample_reader_if;
    import sample_reader_pkg::*;

    logic  mem_rd_en;
    addr_t mem_rd_addr;
    data_t mem_rd_data;
    data_t ser_data;
    logic  ser_valid;
    logic  ser_ready;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output ser_data,
        output ser_valid,
        input  ser_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  ser_data,
        input  ser_valid,
        output ser_ready
    );

endinterface

// File: rtl/sample_prefetch_fifo.sv
// Two-entry prefetch FIFO with synchronous flush; head reads as zero when empty.
module sample_prefetch_fifo
    import sample_reader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  data_t      push_data_i,
    input  logic       pop_i,
    output data_t      head_o,
    output logic [1:0] occ_o
);

    data_t      mem_q [2];
    data_t      mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push, do_pop;

    assign do_push = push_i && (occ_q != 2'd2);
    assign do_pop  = pop_i && (occ_q != 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o  = occ_q;

endmodule

// File: rtl/sample_reader.sv
// Walks the circular sample buffer behind the writer, prefetching up to two words
// from single-cycle-latency memory and handing them to the serializer.
module sample_reader
    import sample_reader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_i,
    input  addr_t             wr_addr_i,
    output logic              empty_o,
    output logic              underrun_o,
    sample_reader_if.master   bus_io
);

    addr_t      rd_addr_q, rd_addr_d;
    logic       inflight_q, inflight_d;
    logic       underrun_q, underrun_d;
    logic [1:0] occ;
    logic [2:0] slots_used;
    logic       ser_valid;
    logic       transfer;
    logic       issue;
    logic       empty;

    assign empty     = (rd_addr_q == wr_addr_i);
    assign ser_valid = (occ != 2'd0);
    assign transfer  = ser_valid && bus_io.ser_ready;

    // A slot freed by this cycle's transfer counts as free, sustaining one word per cycle.
    assign slots_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, transfer};
    assign issue      = enable_i && !empty && (slots_used < 3'd2);

    always_comb begin
        rd_addr_d  = rd_addr_q;
        inflight_d = 1'b0;
        underrun_d = underrun_q;
        if (!enable_i) begin
            rd_addr_d  = '0;
            underrun_d = 1'b0;
        end else begin
            if (issue) begin
                rd_addr_d = addr_wrap_inc(rd_addr_q);
            end
            inflight_d = issue;
            if (bus_io.ser_ready && !ser_valid) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            underrun_q <= underrun_d;
        end
    end

    // Data returning while enable is low belongs to a flushed read and is dropped.
    sample_prefetch_fifo u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (!enable_i),
        .push_i      (inflight_q && enable_i),
        .push_data_i (bus_io.mem_rd_data),
        .pop_i       (transfer),
        .head_o      (bus_io.ser_data),
        .occ_o       (occ)
    );

    assign bus_io.mem_rd_en   = issue;
    assign bus_io.mem_rd_addr = rd_addr_q;
    assign bus_io.ser_valid   = ser_valid;
    assign empty_o            = empty;
    assign underrun_o         = underrun_q;

endmodule

// File: tb/tb_sample_reader.sv
// Scoreboard bench for sample_reader: expected words are queued when the writer
// address is advanced and popped as the serializer accepts them.
module tb_sample_reader;
    import sample_reader_pkg::*;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  enable = 1'b0;
    addr_t wr_addr = '0;
    logic  empty;
    logic  underrun;

    int    checks = 0;
    int    failures = 0;
    data_t exp_q[$];

    sample_reader_if bus ();

    sample_reader dut (
        .clock      (clock),
        .reset      (reset),
        .enable_i   (enable),
        .wr_addr_i  (wr_addr),
        .empty_o    (empty),
        .underrun_o (underrun),
        .bus_io     (bus.master)
    );

    always #5 clock = ~clock;

    // Memory model: word at address a holds a + 0x100, one cycle read latency.
    always @(posedge clock) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_rd_addr + 16'h0100;
    end

    // Transfer monitor: every accepted word must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && bus.ser_valid && bus.ser_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ser_unexpected got=%h expected=none", bus.ser_data);
            end else begin
                data_t e;
                e = exp_q.pop_front();
                if (bus.ser_data !== e) begin
                    failures++;
                    $display("FAIL ser_data got=%h expected=%h", bus.ser_data, e);
                end
            end
        end
    end

    task automatic push_range(input int unsigned first, input int unsigned count);
        for (int unsigned k = 0; k < count; k++) begin
            addr_t a;
            a = addr_t'((first + k) % DEPTH);
            exp_q.push_back(a + 16'h0100);
        end
    endtask

    task automatic rewind();
        @(posedge clock); #1;
        bus.ser_ready = 1'b0;
        enable = 1'b0;
        wr_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain remaining=%0d expected=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        wr_addr = '0;
        bus.ser_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks += 6;
        if (bus.mem_rd_en !== 1'b0) begin
            failures++; $display("FAIL reset_rd_en got=%b expected=0", bus.mem_rd_en);
        end
        if (bus.mem_rd_addr !== 16'h0) begin
            failures++; $display("FAIL reset_rd_addr got=%h expected=0", bus.mem_rd_addr);
        end
        if (bus.ser_data !== 16'h0) begin
            failures++; $display("FAIL reset_ser_data got=%h expected=0", bus.ser_data);
        end
        if (bus.ser_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ser_valid got=%b expected=0", bus.ser_valid);
        end
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL reset_underrun got=%b expected=0", underrun);
        end
        if (empty !== 1'b1) begin
            failures++; $display("FAIL reset_empty got=%b expected=1", empty);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_rd_en !== 1'b0) begin
                failures++; $display("FAIL idle_rd_en cycle=%0d got=1 expected=0", i);
            end
        end
    endtask

    task automatic test_basic_stream();
        rewind();
        enable = 1'b1;
        bus.ser_ready = 1'b1;
        push_range(0, 3);
        wr_addr = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== addr_t'(i)) begin
                failures++;
                $display("FAIL basic_issue%0d got en=%b addr=%0d expected en=1 addr=%0d",
                         i, bus.mem_rd_en, bus.mem_rd_addr, i);
            end
        end
        checks++;
        if (bus.ser_valid !== 1'b1) begin
            failures++; $display("FAIL basic_latency ser_valid=%b expected=1", bus.ser_valid);
        end
        @(negedge clock);
        checks++;
        if (empty !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_empty got empty=%b en=%b expected empty=1 en=0",
                     empty, bus.mem_rd_en);
        end
        drain("basic", 20);
    endtask

    task automatic test_backpressure();
        int pulses;
        rewind();
        enable = 1'b1;
        bus.ser_ready = 1'b0;
        push_range(0, 10);
        wr_addr = 16'd10;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.mem_rd_en) begin
                checks++;
                if (bus.mem_rd_addr !== addr_t'(pulses)) begin
                    failures++;
                    $display("FAIL bp_addr got=%0d expected=%0d", bus.mem_rd_addr, pulses);
                end
                pulses++;
            end
        end
        checks += 2;
        if (pulses != 2) begin
            failures++; $display("FAIL bp_pulses got=%0d expected=2", pulses);
        end
        if (bus.ser_valid !== 1'b1 || bus.ser_data !== 16'h0100) begin
            failures++;
            $display("FAIL bp_hold got valid=%b data=%h expected valid=1 data=0100",
                     bus.ser_valid, bus.ser_data);
        end
        @(posedge clock); #1;
        bus.ser_ready = 1'b1;
        drain("bp", 40);
    endtask

    task automatic test_wrap();
        addr_t seen[$];
        addr_t want[4];
        rewind();
        enable = 1'b1;
        bus.ser_ready = 1'b1;
        push_range(0, LAST_ADDR - 1);
        wr_addr = addr_t'(LAST_ADDR - 1);
        drain("wrap_bulk", 63000);
        @(posedge clock); #1;
        push_range(LAST_ADDR - 1, 4);
        wr_addr = 16'd2;
        want[0] = addr_t'(LAST_ADDR - 1);
        want[1] = addr_t'(LAST_ADDR);
        want[2] = 16'd0;
        want[3] = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.mem_rd_en) seen.push_back(bus.mem_rd_addr);
        end
        checks++;
        if (seen.size() != 4) begin
            failures++; $display("FAIL wrap_count got=%0d expected=4", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                failures++;
                $display("FAIL wrap_addr%0d got=%0d expected=%0d", i, seen[i], want[i]);
            end
        end
        drain("wrap_tail", 20);
    endtask

    task automatic test_underrun();
        rewind();
        enable = 1'b1;
        wr_addr = '0;
        @(negedge clock);
        checks++;
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL underrun_pre got=%b expected=0", underrun);
        end
        @(posedge clock); #1;
        bus.ser_ready = 1'b1;
        @(posedge clock); #1;
        bus.ser_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_set got=%b expected=1", underrun);
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++;
        if (underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_sticky got=%b expected=1", underrun);
        end
        @(posedge clock); #1;
        enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL underrun_clear got=%b expected=0", underrun);
        end
    endtask

    task automatic test_flush();
        int n;
        rewind();
        enable = 1'b1;
        bus.ser_ready = 1'b1;
        push_range(0, 10);
        wr_addr = 16'd10;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.mem_rd_en && bus.mem_rd_addr == 16'd5) && n < 30);
        checks++;
        if (n >= 30) begin
            failures++; $display("FAIL flush_find addr5 issue not seen expected=seen");
        end
        @(posedge clock); #1;
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.mem_rd_en !== 1'b0) begin
            failures++; $display("FAIL flush_rd_en got=%b expected=0", bus.mem_rd_en);
        end
        @(posedge clock);
        exp_q.delete();
        @(negedge clock);
        checks += 2;
        if (bus.ser_valid !== 1'b0) begin
            failures++; $display("FAIL flush_valid got=%b expected=0", bus.ser_valid);
        end
        if (bus.mem_rd_addr !== 16'd0) begin
            failures++; $display("FAIL flush_addr got=%0d expected=0", bus.mem_rd_addr);
        end
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        push_range(0, 10);
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 16'd0) begin
            failures++;
            $display("FAIL flush_restart got en=%b addr=%0d expected en=1 addr=0",
                     bus.mem_rd_en, bus.mem_rd_addr);
        end
        drain("flush", 40);
    endtask

    initial begin
        bus.ser_ready = 1'b0;
        bus.mem_rd_data = '0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_underrun();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
